// File: rtl/fifo_uart_tx.sv
// FIFO-fed asynchronous serial transmitter: 8N1 frames, LSB first, idle-high line.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       F_EMPTY_N,
  input  logic [7:0] FIFO_DATA,
  output logic       READ,
  output logic       TX,
  output logic       BUSY
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             tx_q;
  logic             busy_q;
`ifdef FIFO_UART_TX_PARITY_EN
  logic             parity_q;
`endif

  // Pop is combinational so the FIFO head is consumed on the same edge it is latched.
  assign READ = (state == IDLE) && ENABLE && F_EMPTY_N && !RESET;
  assign TX   = tx_q;
  assign BUSY = busy_q;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx_q    <= 1'b1;
          bit_cnt <= '0;
          bit_idx <= '0;
          if (READ) begin
            shift_reg <= FIFO_DATA;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= ^FIFO_DATA;
`endif
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt <= '0;
            tx_q    <= shift_reg[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state   <= PARITY;
`else
              tx_q    <= 1'b1;
              state   <= STOP;
`endif
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx_q      <= shift_reg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt <= '0;
            tx_q    <= 1'b1;
            state   <= STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt <= '0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4: frame vectors, back-to-back, enable and reset corners.
// Follows FIFO_UART_TX_PARITY_EN to expect the optional parity bit.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       CLOCK;
  logic       RESET;
  logic       ENABLE;
  logic       F_EMPTY_N;
  logic [7:0] FIFO_DATA;
  logic       READ;
  logic       TX;
  logic       BUSY;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] data;
    logic       exp_par;
  } vec_t;

  vec_t vecs[6];

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .ENABLE(ENABLE),
    .F_EMPTY_N(F_EMPTY_N),
    .FIFO_DATA(FIFO_DATA),
    .READ(READ),
    .TX(TX),
    .BUSY(BUSY)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic ne, input logic [7:0] d);
    ENABLE    = en;
    F_EMPTY_N = ne;
    FIFO_DATA = d;
  endtask

  // Expected line level for frame bit k: start, 8 data LSB first, optional parity, stop.
  function automatic logic expBit(input logic [7:0] d, input logic par, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (NBITS == 11 && k == 9) return par;
    return 1'b1;
  endfunction

  // Called just after the pop edge; samples every cycle of the frame.
  task automatic runFrame(input logic [7:0] d, input logic par, input int drop_at);
    int busy_n = 0;
    int read_n = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge CLOCK);
      checkOutput($sformatf("tx_%02h_c%0d", d, i), {31'b0, TX}, {31'b0, expBit(d, par, i / CPB)});
      if (BUSY === 1'b1) busy_n++;
      if (READ !== 1'b0) read_n++;
      if (i == drop_at) ENABLE = 1'b0;
    end
    checkOutput($sformatf("busy_len_%02h", d), busy_n, FRAME);
    checkOutput($sformatf("reads_in_frame_%02h", d), read_n, 0);
  endtask

  task automatic checkIdle(input string name);
    @(negedge CLOCK);
    checkOutput({name, "_tx"}, {31'b0, TX}, 1);
    checkOutput({name, "_busy"}, {31'b0, BUSY}, 0);
  endtask

  initial begin
    int bad;
    int r0;
    int r1;
    int pops;
    int run;
    logic rd;
    logic tx_log[0:199];

    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'h80, 1'b1};
    vecs[5] = '{8'h3C, 1'b0};

    RESET = 1'b1;
    applyStimulus(1'b1, 1'b1, 8'hA5);
    repeat (2) @(negedge CLOCK);
    checkOutput("reset_tx", {31'b0, TX}, 1);
    checkOutput("reset_read", {31'b0, READ}, 0);
    checkOutput("reset_busy", {31'b0, BUSY}, 0);

    applyStimulus(1'b1, 1'b0, 8'hA5);
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLOCK);
      if (READ !== 1'b0 || TX !== 1'b1 || BUSY !== 1'b0) bad++;
    end
    checkOutput("no_traffic_violations", bad, 0);

    for (int v = 0; v < 6; v++) begin
      @(posedge CLOCK); #1;
      applyStimulus(1'b1, 1'b1, vecs[v].data);
      @(negedge CLOCK);
      checkOutput($sformatf("pop_%02h", vecs[v].data), {31'b0, READ}, 1);
      @(posedge CLOCK); #1;
      applyStimulus(1'b1, 1'b0, vecs[v].data);
      runFrame(vecs[v].data, vecs[v].exp_par, -1);
      checkIdle($sformatf("idle_after_%02h", vecs[v].data));
    end

    // ENABLE dropped mid-frame with more data waiting.
    @(posedge CLOCK); #1;
    applyStimulus(1'b1, 1'b1, 8'h5A);
    @(negedge CLOCK);
    checkOutput("pop_5a", {31'b0, READ}, 1);
    @(posedge CLOCK); #1;
    applyStimulus(1'b1, 1'b1, 8'h96);
    runFrame(8'h5A, 1'b0, 10);
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLOCK);
      if (READ !== 1'b0 || TX !== 1'b1 || BUSY !== 1'b0) bad++;
    end
    checkOutput("idle_disabled_violations", bad, 0);
    @(posedge CLOCK); #1;
    ENABLE = 1'b1;
    #1;
    checkOutput("read_on_reenable", {31'b0, READ}, 1);

    // Reset 15 cycles into the 0x96 frame; FIFO has already advanced to 0xC3.
    @(posedge CLOCK); #1;
    applyStimulus(1'b1, 1'b1, 8'hC3);
    for (int i = 0; i < 15; i++) begin
      @(negedge CLOCK);
      checkOutput($sformatf("tx_96_c%0d", i), {31'b0, TX}, {31'b0, expBit(8'h96, 1'b0, i / CPB)});
    end
    @(posedge CLOCK); #1;
    RESET = 1'b1;
    #1;
    checkOutput("midreset_tx", {31'b0, TX}, 1);
    checkOutput("midreset_busy", {31'b0, BUSY}, 0);
    checkOutput("midreset_read", {31'b0, READ}, 0);
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    #1;
    checkOutput("read_after_release", {31'b0, READ}, 1);
    @(negedge CLOCK);
    checkOutput("release_tx_idle", {31'b0, TX}, 1);
    @(posedge CLOCK); #1;
    applyStimulus(1'b1, 1'b0, 8'hC3);
    runFrame(8'hC3, 1'b0, -1);
    checkIdle("idle_after_c3");

    // Back-to-back: FIFO holds 0x00 then 0xFF.
    @(posedge CLOCK); #1;
    applyStimulus(1'b1, 1'b1, 8'h00);
    r0 = -1;
    r1 = -1;
    pops = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLOCK);
      tx_log[c] = TX;
      rd = READ;
      if (rd === 1'b1) begin
        if (pops == 0) r0 = c;
        else if (pops == 1) r1 = c;
      end
      @(posedge CLOCK); #1;
      if (rd === 1'b1) begin
        pops++;
        if (pops == 1) FIFO_DATA = 8'hFF;
        else F_EMPTY_N = 1'b0;
      end
    end
    checkOutput("b2b_pop_count", pops, 2);
    if (r0 < 0 || r1 < 0 || r1 + 1 > 199) begin
      checkOutput("b2b_pops_found", 0, 1);
    end else begin
      checkOutput("b2b_pop_spacing", r1 - r0, FRAME + 1);
      run = 0;
      for (int c = r1; c >= 0 && tx_log[c] === 1'b1; c--) run++;
      checkOutput("b2b_idle_high_run", run, CPB + 1);
      checkOutput("b2b_second_start", {31'b0, tx_log[r1 + 1]}, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
